muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit beside the execute-stage ALU; owns architectural HI/LO.

---
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; muldiv_unit is the slave.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             w_start;
  logic [5:0]       w_op_code_6;
  logic [WIDTH-1:0] w_input1_x;
  logic [WIDTH-1:0] w_input2_x;
  logic             w_busy;
  logic             w_done;
  logic             w_div_by_zero;
  logic [WIDTH-1:0] w_hi_x;
  logic [WIDTH-1:0] w_lo_x;

  modport master (
    output w_start, w_op_code_6, w_input1_x, w_input2_x,
    input  w_busy, w_done, w_div_by_zero, w_hi_x, w_lo_x
  );

  modport slave (
    input  w_start, w_op_code_6, w_input1_x, w_input2_x,
    output w_busy, w_done, w_div_by_zero, w_hi_x, w_lo_x
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning architectural HI/LO.
// One shift-add (mul) or restoring-subtract (div) step per cycle on magnitudes; sign fixed at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     w_clock,
  input  logic     w_reset_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1a;
  localparam logic [5:0] OP_DIVU  = 6'h1b;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   acc_hi_q;   // mul: product high half + carry; div: partial remainder
  logic [WIDTH-1:0] acc_lo_q;   // mul: multiplier / product low; div: dividend / quotient
  logic [WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             is_div_q, qneg_q, rneg_q, dbz_q, done_q;

  // issue decode
  logic             is_mul_op, is_div_op, is_signed, s1, s2, accept;
  logic [WIDTH-1:0] mag1, mag2;
  assign is_mul_op = (bus.w_op_code_6 == OP_MULT) || (bus.w_op_code_6 == OP_MULTU);
  assign is_div_op = (bus.w_op_code_6 == OP_DIV)  || (bus.w_op_code_6 == OP_DIVU);
  assign is_signed = (bus.w_op_code_6 == OP_MULT) || (bus.w_op_code_6 == OP_DIV);
  assign s1        = is_signed & bus.w_input1_x[WIDTH-1];
  assign s2        = is_signed & bus.w_input2_x[WIDTH-1];
  assign mag1      = s1 ? -bus.w_input1_x : bus.w_input1_x;
  assign mag2      = s2 ? -bus.w_input2_x : bus.w_input2_x;
  assign accept    = (state_q == IDLE) && bus.w_start && (is_mul_op || is_div_op);

  // iteration datapath
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  assign mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod      = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_s    = qneg_q ? -prod : prod;
  assign quo_s     = qneg_q ? -acc_lo_q : acc_lo_q;
  // a zero divisor leaves |rs| in the remainder, so re-signing it restores raw rs
  assign rem_s     = rneg_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q    <= CW'(WIDTH-1);
            acc_hi_q <= '0;
            acc_lo_q <= mag1;
            opnd_q   <= is_div_op ? mag2 : mag1;
            if (!is_div_op) acc_lo_q <= mag2;
            is_div_q <= is_div_op;
            qneg_q   <= s1 ^ s2;
            rneg_q   <= s1;
            dbz_q    <= is_div_op && (bus.w_input2_x == '0);
          end else if (bus.w_start && bus.w_op_code_6 == OP_MTHI) begin
            hi_q <= bus.w_input1_x;
          end else if (bus.w_start && bus.w_op_code_6 == OP_MTLO) begin
            lo_q <= bus.w_input1_x;
          end
        end
        RUN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          if (is_div_q) begin
            acc_hi_q <= div_diff[WIDTH] ? div_shift : div_diff;
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_hi_q <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            hi_q <= rem_s;
            lo_q <= dbz_q ? '1 : quo_s;
          end else begin
            hi_q <= prod_s[2*WIDTH-1:WIDTH];
            lo_q <= prod_s[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.w_busy        = (state_q != IDLE);
  assign bus.w_done        = done_q;
  assign bus.w_div_by_zero = done_q & dbz_q;
  assign bus.w_hi_x        = hi_q;
  assign bus.w_lo_x        = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, HI/LO results, div-by-zero, MTHI/MTLO,
// ignored issues while busy/FIX, and asynchronous reset mid-operation.
module tb_muldiv_unit;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1a;
  localparam logic [5:0] OP_DIVU  = 6'h1b;

  logic w_clock = 1'b0;
  logic w_reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.w_clock(w_clock), .w_reset_n(w_reset_n), .bus(bus));

  always #5 w_clock = ~w_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge w_clock);
    bus.w_start = 1'b1; bus.w_op_code_6 = op; bus.w_input1_x = a; bus.w_input2_x = b;
    @(posedge w_clock); #1;
    bus.w_start = 1'b0; bus.w_input1_x = 32'h5a5a_a5a5; bus.w_input2_x = 32'h0;
  endtask

  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input bit inject, input string tag);
    int n = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    start_op(op, a, b);
    while (n < 40 && !seen) begin
      if (bus.w_busy) busy_cnt++;
      @(posedge w_clock); #1;
      n++;
      if (inject) begin
        if (n == 3) begin
          bus.w_start = 1'b1; bus.w_op_code_6 = OP_DIVU;
          bus.w_input1_x = 32'd7; bus.w_input2_x = 32'd0;
        end
        if (n == 4) begin bus.w_op_code_6 = OP_MTHI; bus.w_input1_x = 32'hdead_beef; end
        if (n == 5) bus.w_start = 1'b0;
        if (n == 32) begin
          bus.w_start = 1'b1; bus.w_op_code_6 = OP_MTLO; bus.w_input1_x = 32'h0000_0bad;
        end
        if (n == 33) bus.w_start = 1'b0;
      end
      seen = bus.w_done;
    end
    chk({tag, "_latency"}, 32'(n), 32'd33);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({tag, "_hi"}, bus.w_hi_x, exp_hi);
    chk({tag, "_lo"}, bus.w_lo_x, exp_lo);
    chk({tag, "_dbz"}, 32'(bus.w_div_by_zero), 32'(exp_dbz));
    chk({tag, "_busy_after"}, 32'(bus.w_busy), 32'd0);
    @(posedge w_clock); #1;
    chk({tag, "_done_pulse"}, 32'(bus.w_done), 32'd0);
    chk({tag, "_hold_lo"}, bus.w_lo_x, exp_lo);
  endtask

  initial begin
    bus.w_start = 1'b0; bus.w_op_code_6 = '0; bus.w_input1_x = '0; bus.w_input2_x = '0;
    #12;
    chk("rst_busy", 32'(bus.w_busy), 32'd0);
    chk("rst_done", 32'(bus.w_done), 32'd0);
    chk("rst_dbz",  32'(bus.w_div_by_zero), 32'd0);
    chk("rst_hi",   bus.w_hi_x, 32'd0);
    chk("rst_lo",   bus.w_lo_x, 32'd0);
    @(negedge w_clock); w_reset_n = 1'b1;

    run_op(OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, 1'b0, 1'b0, "multu_max");
    run_op(OP_MULT,  32'hffff_fff9, 32'd3,        32'hffff_ffff, 32'hffff_ffeb, 1'b0, 1'b0, "mult_neg");
    run_op(OP_MULT,  32'hffff_fffe, 32'hffff_fffd, 32'h0,        32'h6,         1'b0, 1'b0, "mult_negneg");
    run_op(OP_DIV,   32'hffff_fff9, 32'd2,        32'hffff_ffff, 32'hffff_fffd, 1'b0, 1'b0, "div_neg");
    run_op(OP_DIVU,  32'hffff_ffff, 32'h10,       32'hf,         32'h0fff_ffff, 1'b0, 1'b0, "divu");
    run_op(OP_DIVU,  32'd100,       32'd0,        32'd100,       32'hffff_ffff, 1'b1, 1'b0, "divu_zero");
    run_op(OP_DIV,   32'hffff_fffb, 32'd0,        32'hffff_fffb, 32'hffff_ffff, 1'b1, 1'b0, "div_zero_neg");
    run_op(OP_DIV,   32'h8000_0000, 32'hffff_ffff, 32'h0,        32'h8000_0000, 1'b0, 1'b0, "div_ovf");

    // MTLO/MTHI write at the issue edge without busy or done
    start_op(OP_MTLO, 32'h0000_1234, 32'h0);
    chk("mtlo_lo",   bus.w_lo_x, 32'h0000_1234);
    chk("mtlo_busy", 32'(bus.w_busy), 32'd0);
    chk("mtlo_done", 32'(bus.w_done), 32'd0);
    start_op(OP_MTHI, 32'h0000_abcd, 32'h0);
    chk("mthi_hi",   bus.w_hi_x, 32'h0000_abcd);
    chk("mthi_lo",   bus.w_lo_x, 32'h0000_1234);

    // unknown op ignored
    start_op(6'h20, 32'h1111_1111, 32'h2);
    chk("badop_busy", 32'(bus.w_busy), 32'd0);
    chk("badop_hi",   bus.w_hi_x, 32'h0000_abcd);

    // DIVU/MTHI while busy and MTLO during FIX must all be dropped
    run_op(OP_MULT, 32'd5, 32'd6, 32'h0, 32'h1e, 1'b0, 1'b1, "mult_inject");
    @(posedge w_clock); #1;
    chk("inject_no_restart", 32'(bus.w_busy), 32'd0);

    // async reset mid-run
    start_op(OP_MULTU, 32'h1234_5678, 32'h9abc_def0);
    repeat (10) @(posedge w_clock);
    #1 w_reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.w_busy), 32'd0);
    chk("midrst_done", 32'(bus.w_done), 32'd0);
    chk("midrst_hi",   bus.w_hi_x, 32'd0);
    chk("midrst_lo",   bus.w_lo_x, 32'd0);
    @(negedge w_clock); w_reset_n = 1'b1;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
